// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB initiator FSM driving SETUP/ACCESS phases for one request at a time
module apb_master_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [2:0]  PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Last counter value before an ACCESS phase with PREADY low is abandoned.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] cnt;
    logic [TO_W-1:0] cnt_nxt;
    logic [2:0]      dec_sel;
    logic [2:0]      psel_nxt;
    logic            penable_nxt;
    logic            pwrite_nxt;
    logic [31:0]     paddr_nxt;
    logic [31:0]     pwdata_nxt;
    logic            rsp_valid_nxt;
    logic [31:0]     rsp_rdata_nxt;
    logic            rsp_err_nxt;

    assign req_ready = (state == IDLE);

    // Map the top address bits onto a one-hot peripheral select; zero means decode miss.
    always_comb begin
        dec_sel = 3'b000;
        case (req_addr[31:26])
            6'b100000: dec_sel = 3'b001;
            6'b100001: dec_sel = 3'b010;
            6'b100010: dec_sel = 3'b100;
            default:   dec_sel = 3'b000;
        endcase
    end

    // Next-state and next-output logic; every output holds unless a transition changes it.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        psel_nxt      = PSEL;
        penable_nxt   = PENABLE;
        pwrite_nxt    = PWRITE;
        paddr_nxt     = PADDR;
        pwdata_nxt    = PWDATA;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (dec_sel != 3'b000) begin
                        psel_nxt    = dec_sel;
                        penable_nxt = 1'b0;
                        paddr_nxt   = req_addr;
                        pwrite_nxt  = req_write;
                        pwdata_nxt  = req_write ? req_wdata : 32'd0;
                        state_nxt   = SETUP;
                    end else begin
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_rdata_nxt = 32'd0;
                        state_nxt     = RESP;
                    end
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                cnt_nxt     = '0;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_rdata_nxt = PWRITE ? 32'd0 : PRDATA;
                    rsp_err_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    psel_nxt      = 3'b000;
                    penable_nxt   = 1'b0;
                    state_nxt     = RESP;
                end else if (cnt == TO_LAST) begin
                    rsp_rdata_nxt = 32'd0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    psel_nxt      = 3'b000;
                    penable_nxt   = 1'b0;
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt = cnt + TO_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Register state and all outputs; reset abandons any transfer without a response.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state     <= IDLE;
            cnt       <= '0;
            PSEL      <= 3'b000;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= 32'd0;
            PWDATA    <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            PSEL      <= psel_nxt;
            PENABLE   <= penable_nxt;
            PWRITE    <= pwrite_nxt;
            PADDR     <= paddr_nxt;
            PWDATA    <= pwdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - directed bench comparing apb_master_ctrl against a transaction-timeline model
module tb_apb_master_ctrl;

    localparam int TIMEOUT = 16;

    logic        Hclk;
    logic        Hreset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    apb_master_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    typedef struct {
        logic        req_ready;
        logic [2:0]  psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        rsp_valid;
        logic [31:0] rsp_rdata;
        logic        rsp_err;
    } exp_t;

    exp_t        mdl;
    bit          chk_en;
    bit          pin_go;
    string       pin_name;
    logic [31:0] pin_act;
    logic [31:0] pin_exp;
    int          tests;
    int          fails;
    int          pen_cnt;

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] e);
        tests++;
        if (act !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, e, $time);
        end
    endtask

    // Compare process: after each rising edge, DUT outputs must equal the model's expectation.
    always @(posedge Hclk) begin
        #1;
        if (PENABLE === 1'b1) pen_cnt++;
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(mdl.req_ready));
            check("PSEL",      32'(PSEL),      32'(mdl.psel));
            check("PENABLE",   32'(PENABLE),   32'(mdl.penable));
            check("PWRITE",    32'(PWRITE),    32'(mdl.pwrite));
            check("PADDR",     PADDR,          mdl.paddr);
            check("PWDATA",    PWDATA,         mdl.pwdata);
            check("rsp_valid", 32'(rsp_valid), 32'(mdl.rsp_valid));
            check("rsp_rdata", rsp_rdata,      mdl.rsp_rdata);
            check("rsp_err",   32'(rsp_err),   32'(mdl.rsp_err));
        end
        if (pin_go) check(pin_name, pin_act, pin_exp);
    end

    // Address map expressed as plain address ranges.
    function automatic logic [2:0] decode(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'h8400_0000) return 3'b001;
        if (a >= 32'h8400_0000 && a < 32'h8800_0000) return 3'b010;
        if (a >= 32'h8800_0000 && a < 32'h8C00_0000) return 3'b100;
        return 3'b000;
    endfunction

    // Number of ACCESS cycles seen when PREADY rises after 'waits' low cycles.
    function automatic int n_access(input int waits);
        return (waits < TIMEOUT) ? waits + 1 : TIMEOUT;
    endfunction

    task automatic next();
        @(negedge Hclk);
    endtask

    task automatic set_reset_exp();
        mdl.req_ready = 1'b1;
        mdl.psel      = 3'b000;
        mdl.penable   = 1'b0;
        mdl.pwrite    = 1'b0;
        mdl.paddr     = 32'd0;
        mdl.pwdata    = 32'd0;
        mdl.rsp_valid = 1'b0;
        mdl.rsp_rdata = 32'd0;
        mdl.rsp_err   = 1'b0;
    endtask

    task automatic busy_inputs(input bit hold);
        req_valid = hold;
        req_addr  = 32'h8800_00F0;
        req_write = 1'b1;
        req_wdata = 32'hBAD0_0000;
        PREADY    = 1'($urandom_range(0, 1));
        PRDATA    = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            PREADY    = 1'($urandom_range(0, 1));
            PRDATA    = $urandom;
            mdl.req_ready = 1'b1;
            mdl.rsp_valid = 1'b0;
            next();
        end
    endtask

    task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] e);
        pin_name = nm;
        pin_act  = act;
        pin_exp  = e;
        pin_go   = 1'b1;
        idle(1);
        pin_go   = 1'b0;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            Hreset    = 1'b1;
            req_valid = 1'b1;
            req_addr  = 32'h8000_0000;
            req_write = 1'b1;
            req_wdata = 32'h5555_AAAA;
            PREADY    = 1'b1;
            PRDATA    = $urandom;
            set_reset_exp();
            chk_en    = 1'b1;
            next();
        end
        Hreset = 1'b0;
    endtask

    // One request: waits = PREADY-low ACCESS cycles (>= TIMEOUT never completes);
    // rst_at > 0 asserts reset during that ACCESS cycle instead of finishing.
    task automatic xfer(input bit write, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input bit hold, input int rst_at);
        logic [2:0] sel;
        int         n;
        sel       = decode(addr);
        req_valid = 1'b1;
        req_write = write;
        req_addr  = addr;
        req_wdata = wdata;
        PREADY    = 1'($urandom_range(0, 1));
        PRDATA    = $urandom;
        mdl.req_ready = 1'b0;
        if (sel == 3'b000) begin
            mdl.rsp_valid = 1'b1;
            mdl.rsp_err   = 1'b1;
            mdl.rsp_rdata = 32'd0;
            next();
        end else begin
            mdl.psel    = sel;
            mdl.penable = 1'b0;
            mdl.paddr   = addr;
            mdl.pwrite  = write;
            mdl.pwdata  = write ? wdata : 32'd0;
            next();
            busy_inputs(hold);
            mdl.penable = 1'b1;
            next();
            n = (rst_at > 0) ? rst_at : n_access(waits);
            for (int k = 1; k <= n; k++) begin
                busy_inputs(hold);
                PREADY = (k == waits + 1);
                if (k == waits + 1) PRDATA = rdata;
                if (rst_at > 0 && k == rst_at) begin
                    Hreset = 1'b1;
                    set_reset_exp();
                    next();
                    Hreset = 1'b0;
                    return;
                end
                if (k == n) begin
                    mdl.psel      = 3'b000;
                    mdl.penable   = 1'b0;
                    mdl.rsp_valid = 1'b1;
                    mdl.rsp_err   = (waits >= TIMEOUT);
                    mdl.rsp_rdata = (waits < TIMEOUT && !write) ? rdata : 32'd0;
                end
                next();
            end
        end
        busy_inputs(hold);
        mdl.rsp_valid = 1'b0;
        mdl.req_ready = 1'b1;
        next();
    endtask

    initial begin
        int base;
        tests     = 0;
        fails     = 0;
        pen_cnt   = 0;
        chk_en    = 1'b0;
        pin_go    = 1'b0;
        pin_name  = "";
        pin_act   = 32'd0;
        pin_exp   = 32'd0;
        Hreset    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        PRDATA    = 32'd0;
        PREADY    = 1'b0;
        set_reset_exp();
        next();

        do_reset(2);
        idle(1);

        pin("model_decode_p1", 32'(decode(32'h8400_0004)), 32'h2);
        pin("model_decode_miss", 32'(decode(32'h9000_0000)), 32'h0);
        pin("model_decode_top", 32'(decode(32'h8BFF_FFFF)), 32'h4);
        pin("model_naccess_3", 32'(n_access(3)), 32'd4);
        pin("model_naccess_to", 32'(n_access(40)), 32'd16);

        xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 0);
        idle(1);

        base = pen_cnt;
        xfer(1'b0, 32'h8400_0004, 32'h0, 3, 32'h1234_5678, 1'b0, 0);
        pin("wait_read_access_cycles", 32'(pen_cnt - base), 32'd4);
        pin("wait_read_rdata_held", rsp_rdata, 32'h1234_5678);

        xfer(1'b0, 32'h9000_0000, 32'h0, 0, 32'h0, 1'b0, 0);
        idle(1);
        xfer(1'b1, 32'h7FFF_FFFC, 32'h1, 0, 32'h0, 1'b0, 0);
        idle(1);

        base = pen_cnt;
        xfer(1'b0, 32'h8800_0000, 32'h0, 100, 32'h0, 1'b0, 0);
        pin("timeout_access_cycles", 32'(pen_cnt - base), 32'd16);
        pin("timeout_err_held", 32'(rsp_err), 32'd1);

        xfer(1'b0, 32'h8800_0000, 32'h0, 15, 32'hCAFE_F00D, 1'b0, 0);
        idle(1);
        xfer(1'b0, 32'h83FF_FFFC, 32'h0, 0, 32'hA5A5_0001, 1'b0, 0);
        idle(1);
        xfer(1'b1, 32'h8BFF_FFF0, 32'h0BAD_F00D, 2, 32'hFFFF_FFFF, 1'b0, 0);
        idle(1);

        xfer(1'b1, 32'h8000_0100, 32'h1111_1111, 0, 32'h0, 1'b1, 0);
        xfer(1'b1, 32'h8400_0200, 32'h2222_2222, 1, 32'h0, 1'b1, 0);
        xfer(1'b1, 32'h8800_0300, 32'h3333_3333, 0, 32'h0, 1'b1, 0);
        idle(2);

        xfer(1'b0, 32'h8400_0000, 32'h0, 100, 32'h0, 1'b0, 2);
        idle(2);
        xfer(1'b0, 32'h8800_0008, 32'h0, 0, 32'h0F0F_1234, 1'b0, 0);
        idle(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- APB initiator (master) FSM of the AHB-to-APB bridge.
- Accepts one transfer at a time on a simple valid/ready request port and drives the APB SETUP/ACCESS phases on PSEL/PENABLE/PWRITE/PADDR/PWDATA.
- Collects PRDATA/PREADY from the peripheral side and returns a one-cycle response pulse carrying read data and an error flag (decode miss or PREADY timeout).

Parameters:
TIMEOUT, 16, max ACCESS cycles with PREADY low before abort (range 1..255)
TO_W, 8, width of timeout counter

Ports:
Hclk  input  1  bridge clock, all logic on rising edge
Hreset  input  1  synchronous active-high reset
req_valid  input  1  transfer request present
req_ready  output  1  request accepted this cycle when req_valid&&req_ready
req_write  input  1  1=write, 0=read
req_addr  input  32  transfer address
req_wdata  input  32  write data
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  read data (valid with rsp_valid on reads; 0 on writes/errors)
rsp_err  output  1  1=decode miss or timeout (valid with rsp_valid)
PSEL  output  3  one-hot peripheral select
PENABLE  output  1  APB access phase
PWRITE  output  1  APB direction
PADDR  output  32  APB address
PWDATA  output  32  APB write data
PRDATA  input  32  APB read data
PREADY  input  1  APB transfer complete

Behaviour:
- Reset (Hreset=1 at an edge): state=IDLE; PSEL=3'b000, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0. Reset mid-transfer aborts immediately; no response is issued for the aborted transfer.
- States: IDLE, SETUP, ACCESS, RESP. All outputs registered; req_ready = (state==IDLE), combinational from state only.
- Address decode at acceptance (req_addr[31:26]):
  - 6'b100000 (0x8000_0000-0x83FF_FFFF) -> PSEL 001
  - 6'b100001 (0x8400_0000-0x87FF_FFFF) -> PSEL 010
  - 6'b100010 (0x8800_0000-0x8BFF_FFFF) -> PSEL 100
  - anything else -> miss
- IDLE, accept with hit: latch PADDR=req_addr, PWRITE=req_write, PWDATA=req_write?req_wdata:0; drive PSEL; PENABLE=0; go to SETUP.
- IDLE, accept with miss: no APB activity (PSEL stays 0); go to RESP with rsp_err=1, rsp_rdata=0.
- SETUP (exactly one cycle): PENABLE<=1 -> ACCESS; counter cleared.
- ACCESS: PSEL, PADDR, PWRITE, PWDATA and PENABLE are held stable.
  - PREADY=1 at an edge: capture rsp_rdata=PWRITE?0:PRDATA, rsp_err=0; PSEL<=0, PENABLE<=0; go to RESP.
  - PREADY=0: counter++. When counter reaches TIMEOUT-1 with PREADY still 0, abort: PSEL<=0, PENABLE<=0, rsp_err=1, rsp_rdata=0; go to RESP.
  - PREADY=1 on the same edge as the timeout takes priority: normal completion.
- RESP: rsp_valid=1 for exactly this cycle; req_ready=0; next state IDLE. rsp_rdata/rsp_err hold their values until the next RESP.
- Latency, zero-wait-state transfer: accept edge N -> SETUP during cycle N+1 -> ACCESS during N+2 -> rsp_valid during N+3 -> next accept possible at end of N+4. Minimum 4 cycles per transfer; decode miss takes 2 cycles.
- req_valid while not IDLE is ignored (not accepted); request inputs are sampled only at the accept edge.
- PRDATA is sampled only at the ACCESS edge where PREADY=1. X on PRDATA at any other time must not propagate.

Test Plan:
- Reset then idle: Hreset=1 for 2 cycles -> all outputs 0, req_ready=1.
- Zero-wait write: req addr 0x8000_0010, wdata 0xDEADBEEF, PREADY tied 1 -> PSEL=001/PENABLE=0 for 1 cycle, PENABLE=1 for 1 cycle with PWDATA=0xDEADBEEF, then rsp_valid=1, rsp_err=0 exactly 3 cycles after accept.
- Wait-state read: addr 0x8400_0004, PREADY low 3 ACCESS cycles then high with PRDATA=0x12345678 -> PSEL=010 held stable through 4 ACCESS cycles; rsp_rdata=0x12345678, rsp_err=0.
- Decode miss: addr 0x9000_0000 -> PSEL stays 000, rsp_valid next cycle with rsp_err=1, rsp_rdata=0.
- Timeout: addr 0x8800_0000, PREADY held 0 -> after 16 ACCESS cycles PSEL=000, PENABLE=0, rsp_err=1. Also repeat with PREADY=1 on the 16th cycle -> normal completion, rsp_err=0.
- Back-to-back plus reset mid-ACCESS: req_valid held high with 3 writes -> accepts spaced 4 cycles apart, req_ready=0 outside IDLE. Hreset asserted during ACCESS -> next cycle PSEL=0, PENABLE=0, no rsp_valid.
